reg_ar_bank: RTL
================

Name: reg_ar_bank

Overview:
- Parametrised bank of CH address registers, each CH entries wide AW bits.
- Every channel supports load, clear and stride increment.
- A burst engine auto-increments one selected channel for a programmed number of cycles, with busy/done handshake.
- Sits between the control unit and memory address path; replaces single-channel AR-style registers where several pointers or block transfers are needed.

Parameters:
- CH, 4: number of address channels (≥2); SELW = $clog2(CH) is a localparam.
- AW, 12: width of each address register.
- DW, 16: width of datain.
- STRIDE, 1: increment step (1 .. 2^AW-1).
- LIMIT, 0: wrap bound. 0 = natural modulo 2^AW; otherwise the value wraps to 0 when the next value is ≥ LIMIT.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- sel  in  SELW  channel addressed by write_en/clr_en/inc_en/burst_start and by dataout
- write_en  in  1  load selected channel from datain
- clr_en  in  1  clear selected channel to 0
- inc_en  in  1  add STRIDE to selected channel
- datain  in  DW  load data: low AW bits used; zero-extended if DW<AW
- burst_start  in  1  request burst on channel sel
- burst_len  in  8  number of burst increments
- dataout  out  AW  value of channel sel, combinational mux of registered state
- busy  out  1  burst in progress
- done  out  1  one-cycle burst completion pulse
- wrap  out  1  registered one-cycle pulse: an increment wrapped on the previous edge

Behaviour:
- Reset (rst=1 at edge):
  - all channels = 0.
  - FSM = IDLE; busy=0, done=0, wrap=0.
  - rst dominates everything, including mid-burst; the burst is abandoned with no done pulse.
- Per-channel command priority (same edge, channel sel): clr_en > write_en > inc_en. Effect is visible on dataout after the edge.
- Increment arithmetic:
  - next = cur + STRIDE computed in AW+1 bits.
  - LIMIT=0: result is next mod 2^AW; wrap if carry out.
  - LIMIT≠0: next ≥ LIMIT gives 0 with wrap; otherwise next.
- Loads are not clamped to LIMIT. A loaded value ≥ LIMIT wraps to 0 on the next increment.
- FSM states: IDLE, RUN, FIN.
  - IDLE: burst_start=1 latches bch=sel and cnt=burst_len.
    - If burst_len≠0, go to RUN and busy=1 after the edge.
    - If burst_len=0, go to FIN with no increment.
  - RUN: each edge increments channel bch by STRIDE and decrements cnt. After the edge where cnt reaches 0, go to FIN.
  - FIN: done=1, busy=0 for exactly one cycle, then IDLE.
- Burst timing: start sampled at edge 0; increments at edges 1..len; done high between edges len and len+1.
- Burst behaviour:
  - burst_start while busy or in FIN is ignored.
  - While busy, write_en/inc_en targeting bch are ignored.
  - clr_en targeting bch clears the channel and aborts the burst: it goes to FIN, the done pulse is still issued, and no increment happens on that edge.
  - Commands to other channels proceed normally and concurrently.
- wrap pulses for any wrapping increment, whether it came from inc_en or from a burst. If both wrap on the same edge, the result is a single pulse.

Optional Feature:
- Macro REG_AR_DEC_EN.
- Defined:
  - Adds port dec_en (in, 1): subtract STRIDE from channel sel, same priority level as inc_en.
  - inc_en and dec_en together: channel holds.
  - Underflow (cur < STRIDE) gives LIMIT-1 (LIMIT≠0) or (cur-STRIDE) mod 2^AW (LIMIT=0), and pulses wrap.
  - dec_en on bch while busy is ignored.
- Undefined: no dec_en port; no decrement logic.

Test Plan:
- Reset, then sweep sel 0..3: dataout=0 for all channels; busy=0, done=0, wrap=0.
- sel=2, write_en, datain=16'hF123: ch2=12'h123. Then write_en+clr_en same edge: ch2=0.
- LIMIT=0, ch1=12'hFFF, inc_en: ch1=0, wrap=1 for one cycle. With LIMIT=10, ch1=9, inc_en: ch1=0, wrap=1.
- ch0=5, burst_start, burst_len=3: busy for 3 cycles, ch0=8 after edge 3, done pulse one cycle. Meanwhile inc_en on ch3 each cycle gives ch3=3. inc_en on ch0 while busy is ignored.
- burst_len=0: no busy; done next cycle; ch unchanged. Second burst_start while busy is ignored.
- Mid-burst clr_en on bch: channel=0, done pulses next cycle. Mid-burst rst: all 0, no done. With REG_AR_DEC_EN, ch0=0, dec_en: ch0=12'hFFF, wrap=1.

Source files
------------

// File: rtl/reg_ar_bank_if.sv
// rtl/reg_ar_bank_if.sv - command/status bundle for the multi-channel address register bank
// Optional port dec_en is present when REG_AR_DEC_EN is defined.
interface reg_ar_bank_if #(
  parameter int CH = 4,
  parameter int AW = 12,
  parameter int DW = 16
);
  localparam int SELW = $clog2(CH);

  logic [SELW-1:0] sel;
  logic            write_en;
  logic            clr_en;
  logic            inc_en;
`ifdef REG_AR_DEC_EN
  logic            dec_en;
`endif
  logic [DW-1:0]   datain;
  logic            burst_start;
  logic [7:0]      burst_len;
  logic [AW-1:0]   dataout;
  logic            busy;
  logic            done;
  logic            wrap;

  modport master (
`ifdef REG_AR_DEC_EN
    output dec_en,
`endif
    output sel, write_en, clr_en, inc_en, datain, burst_start, burst_len,
    input  dataout, busy, done, wrap
  );

  modport slave (
`ifdef REG_AR_DEC_EN
    input  dec_en,
`endif
    input  sel, write_en, clr_en, inc_en, datain, burst_start, burst_len,
    output dataout, busy, done, wrap
  );
endinterface

// File: rtl/reg_ar_bank.sv
// rtl/reg_ar_bank.sv - bank of CH address registers with load/clear/stride increment and a burst engine
// Optional decrement command is enabled by defining REG_AR_DEC_EN.
module reg_ar_bank #(
  parameter int CH     = 4,
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int STRIDE = 1,
  parameter int LIMIT  = 0
) (
  input  logic          clk,
  input  logic          rst,
  reg_ar_bank_if.slave  bus
);
  localparam int SELW = $clog2(CH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   ch_q [CH];
  logic [AW-1:0]   ch_d [CH];
  logic [SELW-1:0] bch_q;
  logic [7:0]      cnt_q;
  logic            wrap_q;
  logic            wrap_d;
  logic            abort;
  logic            cmd_hit;
  logic            burst_hit;
  logic            inc_op;
  logic [AW:0]     step_res;
  logic [AW-1:0]   load_val;
  logic [AW-1:0]   dout;
  logic [AW+DW-1:0] datain_ext;
  logic            unused_datain_hi;
`ifdef REG_AR_DEC_EN
  logic            dec_op;
`endif

  // Returns {wrap, value} for cur + STRIDE, honouring the LIMIT wrap bound.
  function automatic logic [AW:0] f_inc(input logic [AW-1:0] cur);
    logic [AW:0] nxt;
    nxt = {1'b0, cur} + (AW+1)'(STRIDE);
    if (LIMIT == 0) begin
      f_inc = nxt;
    end else if (nxt >= (AW+1)'(LIMIT)) begin
      f_inc = {1'b1, {AW{1'b0}}};
    end else begin
      f_inc = {1'b0, nxt[AW-1:0]};
    end
  endfunction

`ifdef REG_AR_DEC_EN
  // Returns {wrap, value} for cur - STRIDE; underflow lands on LIMIT-1 when bounded.
  function automatic logic [AW:0] f_dec(input logic [AW-1:0] cur);
    if (cur < AW'(STRIDE)) begin
      if (LIMIT == 0) begin
        f_dec = {1'b1, cur - AW'(STRIDE)};
      end else begin
        f_dec = {1'b1, AW'(LIMIT - 1)};
      end
    end else begin
      f_dec = {1'b0, cur - AW'(STRIDE)};
    end
  endfunction
`endif

  // Low AW bits of datain, zero-extended when datain is narrower.
  assign datain_ext       = {{AW{1'b0}}, bus.datain};
  assign load_val         = datain_ext[AW-1:0];
  assign unused_datain_hi = ^datain_ext[AW+DW-1:AW];

`ifdef REG_AR_DEC_EN
  assign inc_op = bus.inc_en & ~bus.dec_en;
  assign dec_op = bus.dec_en & ~bus.inc_en;
`else
  assign inc_op = bus.inc_en;
`endif

  // A clear on the bursting channel ends the burst early.
  assign abort = (state_q == RUN) && bus.clr_en && (bus.sel == bch_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.burst_start) state_d = (bus.burst_len != 8'd0) ? RUN : FIN;
      RUN:  if (abort || cnt_q == 8'd1) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == FIN);
  end

  // Burst channel and remaining-count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bch_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && bus.burst_start) begin
      bch_q <= bus.sel;
      cnt_q <= bus.burst_len;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Per-channel next value: clear wins, then burst ownership, then load, then step.
  always_comb begin
    ch_d      = ch_q;
    wrap_d    = 1'b0;
    cmd_hit   = 1'b0;
    burst_hit = 1'b0;
    step_res  = '0;
    for (int i = 0; i < CH; i++) begin
      cmd_hit   = (bus.sel == SELW'(i));
      burst_hit = (state_q == RUN) && (bch_q == SELW'(i));
      if (cmd_hit && bus.clr_en) begin
        ch_d[i] = '0;
      end else if (burst_hit) begin
        step_res = f_inc(ch_q[i]);
        ch_d[i]  = step_res[AW-1:0];
        wrap_d   = wrap_d | step_res[AW];
      end else if (cmd_hit && bus.write_en) begin
        ch_d[i] = load_val;
      end else if (cmd_hit && inc_op) begin
        step_res = f_inc(ch_q[i]);
        ch_d[i]  = step_res[AW-1:0];
        wrap_d   = wrap_d | step_res[AW];
`ifdef REG_AR_DEC_EN
      end else if (cmd_hit && dec_op) begin
        step_res = f_dec(ch_q[i]);
        ch_d[i]  = step_res[AW-1:0];
        wrap_d   = wrap_d | step_res[AW];
`endif
      end
    end
  end

  // Channel registers and the registered wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) ch_q[i] <= '0;
      wrap_q <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      wrap_q <= wrap_d;
    end
  end

  // Read mux: value of the channel addressed by sel.
  always_comb begin
    dout = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.sel == SELW'(i)) dout = ch_q[i];
    end
  end

  assign bus.dataout = dout;
  assign bus.wrap    = wrap_q;

endmodule
